// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- sequencing controller for the 5-stage pipeline.
//
// This block drives the write enables and flushes for the PC, IF/ID and ID/EX
// registers. It handles four things:
//   - load-use interlocks,
//   - branch and jump squashes,
//   - multi-cycle MULT/DIV occupancy,
//   - entry to an external interrupt at a safe pipeline boundary.
// EX/MEM and MEM/WB always advance and are not controlled here.
//
// Parameters:
//   MD_LATENCY  cycles the MULT/DIV unit stays busy after a start is accepted
//   CNT_W       width of the MULT/DIV busy counter
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   ID_*                decode-stage instruction fields and flags
//   EX_*                execute-stage load/destination/branch status
//   IRQ                 level interrupt request (latched into the FSM)
//   PC_Wr, IFID_Wr      pipeline register write enables
//   IFID_Flush          zero IF/ID on the next edge
//   IDEX_Flush          insert a bubble into ID/EX
//   MD_Busy             MULT/DIV counter nonzero
//   PC_Sel_Irq, Irq_Ack interrupt vector select and one-cycle EPC capture
//   Stall_Cnt           free-running count of stall cycles; present only
//                       when the PIPE_STALL_CNT_EN macro is defined
module pipe_hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRt,
  input  logic       ID_Jump,
  input  logic       ID_MdStart,
  input  logic       ID_MdRead,
  input  logic       ID_Eret,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_WrReg,
  input  logic       EX_BranchTaken,
  input  logic       IRQ,
  output logic       PC_Wr,
  output logic       IFID_Wr,
  output logic       IFID_Flush,
  output logic       IDEX_Flush,
  output logic       MD_Busy,
  output logic       PC_Sel_Irq,
  output logic       Irq_Ack
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0] Stall_Cnt
`endif
);

  typedef enum logic [1:0] {IDLE, PEND, INSVC} irq_state_t;

  localparam logic [CNT_W-1:0] MD_LAT_C = CNT_W'(MD_LATENCY);

  irq_state_t       irq_state, irq_next;
  logic [CNT_W-1:0] md_cnt;
  logic             ldu, mdh, stall, take, md_load;

  assign MD_Busy = (md_cnt != '0);

  assign ldu = EX_MemRead && (EX_WrReg != 5'd0) &&
               ((EX_WrReg == ID_Rs) || (ID_UsesRt && (EX_WrReg == ID_Rt)));
  assign mdh   = MD_Busy && (ID_MdStart || ID_MdRead);
  assign stall = (ldu || mdh) && !EX_BranchTaken;
  // Interrupt entry waits for the MULT/DIV unit to drain, so that EPC never
  // points into an instruction whose result is still in flight.
  assign take  = (irq_state == PEND) && !stall && !EX_BranchTaken && !MD_Busy;

  assign md_load = ID_MdStart && !MD_Busy && !EX_BranchTaken && !ldu && !take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (md_load) begin
      md_cnt <= MD_LAT_C;
    end else if (MD_Busy) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_state <= IDLE;
    end else begin
      irq_state <= irq_next;
    end
  end

  always_comb begin
    irq_next = irq_state;
    unique case (irq_state)
      IDLE:    if (IRQ) irq_next = PEND;
      PEND:    if (take) irq_next = INSVC;
      INSVC:   if (ID_Eret && !stall && !EX_BranchTaken) irq_next = IDLE;
      default: irq_next = IDLE;
    endcase
  end

  // Output priority: branch squash > stall bubble > interrupt entry > jump.
  always_comb begin
    PC_Wr      = 1'b1;
    IFID_Wr    = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Flush = 1'b0;
    PC_Sel_Irq = 1'b0;
    Irq_Ack    = 1'b0;
    if (EX_BranchTaken) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (stall) begin
      PC_Wr      = 1'b0;
      IFID_Wr    = 1'b0;
      IDEX_Flush = 1'b1;
    end else if (take) begin
      PC_Sel_Irq = 1'b1;
      Irq_Ack    = 1'b1;
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (ID_Jump) begin
      IFID_Flush = 1'b1;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Stall_Cnt <= '0;
    end else if (stall) begin
      Stall_Cnt <= Stall_Cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_Rs, ID_Rt, EX_WrReg;
  logic       ID_UsesRt, ID_Jump, ID_MdStart, ID_MdRead, ID_Eret;
  logic       EX_MemRead, EX_BranchTaken, IRQ;
  logic       PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush, MD_Busy, PC_Sel_Irq, Irq_Ack;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] Stall_Cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Packed output order: PC_Wr IFID_Wr IFID_Flush IDEX_Flush MD_Busy PC_Sel_Irq Irq_Ack
  localparam logic [6:0] O_RUN   = 7'b1100000;
  localparam logic [6:0] O_STALL = 7'b0001000;
  localparam logic [6:0] O_MDSTL = 7'b0001100;
  localparam logic [6:0] O_BUSY  = 7'b1100100;
  localparam logic [6:0] O_BR    = 7'b1111000;
  localparam logic [6:0] O_TAKE  = 7'b1111011;
  localparam logic [6:0] O_JUMP  = 7'b1110000;

  pipe_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_Jump(ID_Jump),
    .ID_MdStart(ID_MdStart), .ID_MdRead(ID_MdRead), .ID_Eret(ID_Eret),
    .EX_MemRead(EX_MemRead), .EX_WrReg(EX_WrReg), .EX_BranchTaken(EX_BranchTaken),
    .IRQ(IRQ),
    .PC_Wr(PC_Wr), .IFID_Wr(IFID_Wr), .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .MD_Busy(MD_Busy), .PC_Sel_Irq(PC_Sel_Irq), .Irq_Ack(Irq_Ack)
`ifdef PIPE_STALL_CNT_EN
    , .Stall_Cnt(Stall_Cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; ID_Jump = 1'b0;
    ID_MdStart = 1'b0; ID_MdRead = 1'b0; ID_Eret = 1'b0;
    EX_MemRead = 1'b0; EX_WrReg = 5'd0; EX_BranchTaken = 1'b0; IRQ = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    #1;
    obs = {PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush, MD_Busy, PC_Sel_Irq, Irq_Ack};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic load_use(input logic [4:0] r);
    EX_MemRead = 1'b1; EX_WrReg = r; ID_Rs = r;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    check("reset_state", O_RUN);
    tick(); tick();
    reset = 1'b0;

    // Load-use on rs: exactly one bubble cycle.
    load_use(5'd8);
    check("ldu_rs_stall", O_STALL);
    tick();
    EX_MemRead = 1'b0; EX_WrReg = 5'd0;
    check("ldu_rs_release", O_RUN);
    tick();
    // Load-use on rt only when the instruction reads rt.
    EX_MemRead = 1'b1; EX_WrReg = 5'd9; ID_Rs = 5'd1; ID_Rt = 5'd9; ID_UsesRt = 1'b1;
    check("ldu_rt_stall", O_STALL);
    ID_UsesRt = 1'b0;
    check("ldu_rt_unused", O_RUN);
    // A load targeting r0 never interlocks.
    clear_inputs();
    EX_MemRead = 1'b1;
    check("ldu_r0_none", O_RUN);
    tick();
    clear_inputs();

    // MULT accepted at t, MFLO in ID from t+1 stalls four cycles, issues at t+5.
    ID_MdStart = 1'b1;
    check("mult_accept", O_RUN);
    tick();
    ID_MdStart = 1'b0; ID_MdRead = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mflo_stall_%0d", i), O_MDSTL);
      tick();
    end
    check("mflo_issue", O_RUN);
    tick();
    clear_inputs();

    // Back-to-back MULT waits for the first to finish.
    ID_MdStart = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mult_b2b_stall_%0d", i), O_MDSTL);
      tick();
    end
    check("mult_b2b_accept", O_RUN);
    tick();
    ID_MdStart = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mult_b2b_drained", O_RUN);

    // Branch beats load-use and a MULT start in the same cycle.
    load_use(5'd8); ID_MdStart = 1'b1; EX_BranchTaken = 1'b1;
    check("branch_priority", O_BR);
    tick();
    clear_inputs();
    check("branch_no_md_start", O_RUN);

    // Interrupt raised while MULT/DIV busy (cnt=3) is held pending.
    ID_MdStart = 1'b1;
    tick();
    ID_MdStart = 1'b0;
    tick();
    IRQ = 1'b1;
    check("irq_raise_cnt3", O_BUSY);
    tick();
    IRQ = 1'b0;
    check("irq_pend_cnt2", O_BUSY);
    tick();
    check("irq_pend_cnt1", O_BUSY);
    tick();
    check("irq_take", O_TAKE);
    tick();
    check("irq_insvc_once", O_RUN);
    IRQ = 1'b1;
    tick();
    IRQ = 1'b0;
    check("irq_nested_ignored", O_RUN);
    // ERET under a stall does not leave service.
    load_use(5'd3); ID_Eret = 1'b1;
    check("eret_stalled", O_STALL);
    tick();
    clear_inputs();
    IRQ = 1'b1;
    tick();
    IRQ = 1'b0;
    check("eret_stalled_still_insvc", O_RUN);
    ID_Eret = 1'b1;
    tick();
    ID_Eret = 1'b0;
    // Back in IDLE: a new request pends, is blocked by a stall, then taken.
    IRQ = 1'b1;
    tick();
    IRQ = 1'b0;
    load_use(5'd5);
    check("irq_pend_blocked_by_stall", O_STALL);
    tick();
    clear_inputs();
    check("irq_take_after_eret", O_TAKE);
    tick();
    ID_Eret = 1'b1;
    tick();
    clear_inputs();

    // Jump held while stalled, acted on the following cycle.
    load_use(5'd7); ID_Jump = 1'b1;
    check("jump_under_stall", O_STALL);
    tick();
    EX_MemRead = 1'b0; EX_WrReg = 5'd0;
    check("jump_after_stall", O_JUMP);
    tick();
    clear_inputs();

    // Asynchronous reset in the middle of a MULT/DIV stall.
    ID_MdStart = 1'b1;
    tick();
    ID_MdStart = 1'b0; ID_MdRead = 1'b1;
    check("pre_reset_stall", O_MDSTL);
    #2 reset = 1'b1;
    check("async_reset_immediate", O_RUN);
`ifdef PIPE_STALL_CNT_EN
    vectors++;
    assert (Stall_Cnt === 32'd0) else begin
      miscompares++;
      $error("FAIL stall_cnt_reset: observed %0d expected 0", Stall_Cnt);
    end
`endif
    tick();
    reset = 1'b0;
    clear_inputs();
    check("post_reset_run", O_RUN);
`ifdef PIPE_STALL_CNT_EN
    load_use(5'd4);
    tick(); tick();
    clear_inputs();
    vectors++;
    assert (Stall_Cnt === 32'd2) else begin
      miscompares++;
      $error("FAIL stall_cnt_two: observed %0d expected 2", Stall_Cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
